// File: rtl/sram_tp_be_arb.sv
// Round-robin arbiter for a two-port column-enable SRAM: wr0/wr1 share the write port,
// rd0/rd1 share the read port, and reads that hit a same-cycle write address are held off.
module sram_tp_be_arb #(
    parameter int ADR_WD = 5,
    parameter int DAT_WD = 32,
    parameter int COL_WD = 8,
    localparam int NCOL  = DAT_WD / COL_WD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr0_req,
    input  logic [NCOL-1:0]   i_wr0_ena,
    input  logic [ADR_WD-1:0] i_wr0_adr,
    input  logic [DAT_WD-1:0] i_wr0_dat,
    output logic              o_wr0_ack,
    input  logic              i_wr1_req,
    input  logic [NCOL-1:0]   i_wr1_ena,
    input  logic [ADR_WD-1:0] i_wr1_adr,
    input  logic [DAT_WD-1:0] i_wr1_dat,
    output logic              o_wr1_ack,
    input  logic              i_rd0_req,
    input  logic [ADR_WD-1:0] i_rd0_adr,
    output logic              o_rd0_ack,
    output logic              o_rd0_val,
    output logic [DAT_WD-1:0] o_rd0_dat,
    input  logic              i_rd1_req,
    input  logic [ADR_WD-1:0] i_rd1_adr,
    output logic              o_rd1_ack,
    output logic              o_rd1_val,
    output logic [DAT_WD-1:0] o_rd1_dat,
    output logic [NCOL-1:0]   o_sram_wr_ena,
    output logic [ADR_WD-1:0] o_sram_wr_adr,
    output logic [DAT_WD-1:0] o_sram_wr_dat,
    output logic              o_sram_rd_ena,
    output logic [ADR_WD-1:0] o_sram_rd_adr,
    input  logic [DAT_WD-1:0] i_sram_rd_dat
);

    logic r_wr_ptr;
    logic r_rd_ptr;
    logic r_rd_pend;
    logic r_rd_tag;

    logic w_wr_gnt0;
    logic w_wr_gnt1;
    logic w_wr_any;
    logic w_rd_elig0;
    logic w_rd_elig1;
    logic w_rd_gnt0;
    logic w_rd_gnt1;
    logic w_rd_any;

    always_comb begin
        w_wr_gnt0 = 1'b0;
        w_wr_gnt1 = 1'b0;
        if (!rst) begin
            w_wr_gnt0 = i_wr0_req && (!i_wr1_req || !r_wr_ptr);
            w_wr_gnt1 = i_wr1_req && (!i_wr0_req ||  r_wr_ptr);
        end
    end

    assign w_wr_any  = w_wr_gnt0 || w_wr_gnt1;
    assign o_wr0_ack = w_wr_gnt0;
    assign o_wr1_ack = w_wr_gnt1;

    always_comb begin
        o_sram_wr_ena = '0;
        o_sram_wr_adr = '0;
        o_sram_wr_dat = '0;
        if (w_wr_gnt0) begin
            o_sram_wr_ena = i_wr0_ena;
            o_sram_wr_adr = i_wr0_adr;
            o_sram_wr_dat = i_wr0_dat;
        end else if (w_wr_gnt1) begin
            o_sram_wr_ena = i_wr1_ena;
            o_sram_wr_adr = i_wr1_adr;
            o_sram_wr_dat = i_wr1_dat;
        end
    end

    // A read to the address being written this cycle would return stale data; defer it.
    assign w_rd_elig0 = i_rd0_req &&
                        !(w_wr_any && |o_sram_wr_ena && (i_rd0_adr == o_sram_wr_adr));
    assign w_rd_elig1 = i_rd1_req &&
                        !(w_wr_any && |o_sram_wr_ena && (i_rd1_adr == o_sram_wr_adr));

    always_comb begin
        w_rd_gnt0 = 1'b0;
        w_rd_gnt1 = 1'b0;
        if (!rst) begin
            w_rd_gnt0 = w_rd_elig0 && (!w_rd_elig1 || !r_rd_ptr);
            w_rd_gnt1 = w_rd_elig1 && (!w_rd_elig0 ||  r_rd_ptr);
        end
    end

    assign w_rd_any  = w_rd_gnt0 || w_rd_gnt1;
    assign o_rd0_ack = w_rd_gnt0;
    assign o_rd1_ack = w_rd_gnt1;

    always_comb begin
        o_sram_rd_ena = 1'b0;
        o_sram_rd_adr = '0;
        if (w_rd_gnt0) begin
            o_sram_rd_ena = 1'b1;
            o_sram_rd_adr = i_rd0_adr;
        end else if (w_rd_gnt1) begin
            o_sram_rd_ena = 1'b1;
            o_sram_rd_adr = i_rd1_adr;
        end
    end

    // Pointers move to the requester that did not win; granting 0 points at 1 and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            if (w_wr_any) r_wr_ptr <= w_wr_gnt0;
            if (w_rd_any) r_rd_ptr <= w_rd_gnt0;
            r_rd_pend <= w_rd_any;
            r_rd_tag  <= w_rd_gnt1;
        end
    end

    assign o_rd0_val = r_rd_pend && !r_rd_tag;
    assign o_rd1_val = r_rd_pend &&  r_rd_tag;
    assign o_rd0_dat = o_rd0_val ? i_sram_rd_dat : '0;
    assign o_rd1_dat = o_rd1_val ? i_sram_rd_dat : '0;

endmodule
